// File: rtl/mod_add.sv
// Registered 48-bit modular adder: B = (A + M) with one conditional subtraction of q.
// Define MOD_ADD_RANGE_CHECK_EN to add the registered err output flagging A or M >= q.
module mod_add (
  input  logic        clk,
  input  logic        rstn,
  input  logic [47:0] A,
  input  logic [47:0] M,
  input  logic [47:0] q,
  output logic [47:0] B
`ifdef MOD_ADD_RANGE_CHECK_EN
  ,
  output logic        err
`endif
);

  logic [48:0] w_sum;
  logic [47:0] w_diff;
  logic        w_q_nz;
  logic        w_wrap;
  logic [47:0] w_next;
  logic [47:0] r_b;

  // The carry into bit 48 must take part in the compare, so the sum is widened first.
  assign w_sum  = {1'b0, A} + {1'b0, M};
  // The low 48 bits of S - q depend only on the low 48 bits of S.
  assign w_diff = w_sum[47:0] - q;
  assign w_q_nz = |q;
  assign w_wrap = w_q_nz && (w_sum >= {1'b0, q});
  assign w_next = w_wrap ? w_diff : w_sum[47:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_b <= '0;
    end else begin
      r_b <= w_next;
    end
  end

  assign B = r_b;

`ifdef MOD_ADD_RANGE_CHECK_EN
  logic w_range_err;
  logic r_err;

  assign w_range_err = w_q_nz && ((A >= q) || (M >= q));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_range_err;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_mod_add.sv
// Directed self-checking bench for mod_add; checks reset, wrap/no-wrap, boundaries,
// back-to-back issue and, with MOD_ADD_RANGE_CHECK_EN defined, the err flag.
module tb_mod_add;

  logic        clk;
  logic        rstn;
  logic [47:0] A;
  logic [47:0] M;
  logic [47:0] q;
  logic [47:0] B;
`ifdef MOD_ADD_RANGE_CHECK_EN
  logic        err;
`endif

  int checks;
  int errors;

  mod_add dut (
    .clk  (clk),
    .rstn (rstn),
    .A    (A),
    .M    (M),
    .q    (q),
    .B    (B)
`ifdef MOD_ADD_RANGE_CHECK_EN
    ,
    .err  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] MAX48 = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] BIGQ  = 48'd281474976710129;

  // Drive one operand set, clock it in, and compare B 1 time unit after the edge.
  task automatic apply_check(input string name, input logic [47:0] a, input logic [47:0] m,
                             input logic [47:0] qq, input logic [47:0] exp_b);
    A = a;
    M = m;
    q = qq;
    @(posedge clk);
    #1;
    checks++;
    if (B !== exp_b) begin
      errors++;
      $display("FAIL %s: B=%0d expected %0d", name, B, exp_b);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    A = MAX48;
    M = 48'd12345;
    q = 48'd7;
    @(posedge clk);
    #1;
    checks++;
    if (B !== 48'd0) begin
      errors++;
      $display("FAIL reset_b: B=%0d expected 0", B);
    end
`ifdef MOD_ADD_RANGE_CHECK_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%0b expected 0", err);
    end
`endif
    rstn = 1'b0;
    apply_check("reset_release", 48'd3, 48'd4, 48'd100, 48'd7);
  endtask

  task automatic test_wrap();
    apply_check("wrap_1", 48'd263230795212639, 48'd47918723023213, BIGQ, 48'd29674541525723);
    apply_check("wrap_2", 48'd136216848817676, 48'd192751993893431, BIGQ, 48'd47493866000978);
    apply_check("nowrap", 48'd89084525283856, 48'd178054022353922, BIGQ, 48'd267138547637778);
  endtask

  task automatic test_boundaries();
    apply_check("sum_eq_q", 48'd600, 48'd400, 48'd1000, 48'd0);
    apply_check("zero_zero", 48'd0, 48'd0, 48'd1000, 48'd0);
    apply_check("carry48", MAX48 - 48'd1, MAX48 - 48'd1, MAX48, MAX48 - 48'd2);
    apply_check("q_zero_wrap", 48'h8000_0000_0000, 48'h8000_0000_0000, 48'd0, 48'd0);
    apply_check("q_zero_plain", 48'd5, 48'd7, 48'd0, 48'd12);
    apply_check("one_below_q", 48'd499, 48'd500, 48'd1000, 48'd999);
  endtask

  // Output must not react to input changes between edges.
  task automatic test_registered_output();
    apply_check("hold_setup", 48'd10, 48'd20, 48'd97, 48'd30);
    A = 48'd90;
    M = 48'd90;
    q = 48'd97;
    #2;
    checks++;
    if (B !== 48'd30) begin
      errors++;
      $display("FAIL hold_no_comb: B=%0d expected 30", B);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] va [6];
    logic [47:0] vm [6];
    logic [47:0] vq [6];
    logic [47:0] ve [6];
    va = '{48'd10, 48'd50, 48'd96, 48'd0, 48'd5, MAX48};
    vm = '{48'd20, 48'd60, 48'd96, 48'd0, 48'd7, 48'd1};
    vq = '{48'd97, 48'd97, 48'd97, 48'd97, 48'd0, 48'd0};
    ve = '{48'd30, 48'd13, 48'd95, 48'd0, 48'd12, 48'd0};
    for (int i = 0; i < 6; i++) begin
      apply_check($sformatf("b2b_%0d", i), va[i], vm[i], vq[i], ve[i]);
    end
  endtask

  task automatic test_mid_reset();
    apply_check("pre_reset", 48'd40, 48'd70, 48'd100, 48'd10);
    A = 48'd60;
    M = 48'd60;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (B !== 48'd0) begin
      errors++;
      $display("FAIL mid_reset: B=%0d expected 0", B);
    end
    rstn = 1'b0;
    apply_check("post_reset", 48'd60, 48'd60, 48'd100, 48'd20);
  endtask

`ifdef MOD_ADD_RANGE_CHECK_EN
  task automatic test_range_check();
    apply_check("range_b", 48'd1000, 48'd5, 48'd1000, 48'd5);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_err_a: err=%0b expected 1", err);
    end
    apply_check("range_m_b", 48'd5, 48'd2000, 48'd1000, 48'd1005);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_err_m: err=%0b expected 1", err);
    end
    apply_check("inrange_b", 48'd999, 48'd999, 48'd1000, 48'd998);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_ok: err=%0b expected 0", err);
    end
    apply_check("qzero_b", 48'd9, 48'd9, 48'd0, 48'd18);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL range_err_q0: err=%0b expected 0", err);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b1;
    A = '0;
    M = '0;
    q = '0;
    #2;
    test_reset();
    test_wrap();
    test_boundaries();
    test_registered_output();
    test_back_to_back();
    test_mid_reset();
`ifdef MOD_ADD_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_add.md
MOD_ADD -- requirements
Module: mod_add

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk and rstn, with rstn=1 sampled at a rising clk edge meaning reset.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rstn  input  1  synchronous active-high reset (1 = reset asserted, despite the name).
REQ-004 A  input  48  first addend, unsigned.
REQ-005 M  input  48  second addend, unsigned.
REQ-006 q  input  48  modulus, unsigned.
REQ-007 B  output  48  registered result.
REQ-008 err  output  1  range-violation flag; present only when MOD_ADD_RANGE_CHECK_EN is defined.

Function
REQ-009 At each rising clk edge with rstn=0, the block SHALL compute S = A + M as a 49-bit unsigned sum, with no truncation before comparison.
REQ-010 If q != 0 and S >= q, B SHALL load (S - q)[47:0]; otherwise B SHALL load S[47:0].
REQ-011 If q == 0, B SHALL load S[47:0], i.e. the sum mod 2^48.
REQ-012 Only a single conditional subtraction SHALL be performed.
  - Result is exact (A + M) mod q when A < q and M < q.
  - Out-of-range inputs produce the single-subtraction value defined above, with no further reduction.
REQ-013 Latency SHALL be exactly 1 clock: the result for inputs sampled at edge n appears on B right after edge n and holds until edge n+1.
REQ-014 The block SHALL be fully pipelined, accepting new A, M and q every cycle with no handshake and no stall.
REQ-015 B SHALL be driven only from the output register, with no combinational path from inputs to B.
REQ-016 Boundary cases:
  - S == q SHALL give 0.
  - A = M = 0 SHALL give 0.
  - S carry into bit 48 SHALL be handled without loss, e.g. A = M = q-1 with q = 2^48-1 gives q-2.

Reset
REQ-017 When rstn=1 at a rising clk edge, B SHALL become 0 (and err 0 if present), overriding any computation.
REQ-018 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-019 The first edge after rstn returns to 0 SHALL load a normal result from the current inputs.
REQ-020 Before the first reset, output values SHALL be treated as don't-care.

Configuration
REQ-021 With macro MOD_ADD_RANGE_CHECK_EN defined, output err SHALL be registered with the same 1-cycle latency as B.
REQ-022 err SHALL be 1 when q != 0 and (A >= q or M >= q), and 0 otherwise.
REQ-023 With MOD_ADD_RANGE_CHECK_EN undefined, the err port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-024 Reset: rstn=1 for 1 edge with any inputs -> B=0 after that edge; release -> B tracks inputs after the next edge.
REQ-025 Wrap case: q=281474976710129, A=263230795212639, M=47918723023213 -> B=29674541525723 one cycle later.
REQ-026 Wrap case: same q, A=136216848817676, M=192751993893431 -> B=47493866000978.
REQ-027 No-wrap case: same q, A=89084525283856, M=178054022353922 -> B=267138547637778.
REQ-028 Boundaries:
  - q=1000, A=600, M=400 -> B=0.
  - q=2^48-1, A=M=2^48-2 -> B=2^48-3.
  - q=0, A=M=2^47 -> B=0.
REQ-029 Back-to-back and range check:
  - New inputs every cycle -> each result appears exactly one cycle later.
  - With MOD_ADD_RANGE_CHECK_EN defined: q=1000, A=1000, M=5 -> err=1 and B=5.
